// File: rtl/cmp_stream_tracker_pkg.sv
// Shared definitions for the comparator stream tracker: FSM encoding and
// counter saturation helper.
package cmp_stream_tracker_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

  // All-ones value for a counter of width w; counters hold here instead of wrapping.
  function automatic longint unsigned cnt_sat(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/cmp_unit.sv
// Unsigned WIDTH-bit magnitude comparator; exactly one output is high for any inputs.
module cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_ls_b,
  output logic             a_eq_b
);

  assign a_gt_b = (a > b);
  assign a_ls_b = (a < b);
  assign a_eq_b = (a == b);

endmodule

// File: rtl/cmp_stream_tracker.sv
// Compares each accepted sample with the previous one, tracks running max/min
// and keeps saturating rise/fall/equal/sample counters.
module cmp_stream_tracker
  import cmp_stream_tracker_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             cur_gt,
  output logic             cur_ls,
  output logic             cur_eq,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic             accept;
  logic             prev_gt, prev_ls, prev_eq;
  logic             max_gt, max_ls, max_eq;
  logic             min_gt, min_ls, min_eq;
  logic             max_upd, min_upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign in_ready = ~clear;
  assign accept   = in_valid & in_ready;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_prev (
    .a(in_data), .b(prev), .a_gt_b(prev_gt), .a_ls_b(prev_ls), .a_eq_b(prev_eq)
  );

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (
    .a(in_data), .b(max_val), .a_gt_b(max_gt), .a_ls_b(max_ls), .a_eq_b(max_eq)
  );

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (
    .a(in_data), .b(min_val), .a_gt_b(min_gt), .a_ls_b(min_ls), .a_eq_b(min_eq)
  );

  // A bound moves only on a clean one-hot verdict from its comparator.
  assign max_upd = max_gt & ~max_ls & ~max_eq;
  assign min_upd = min_ls & ~min_gt & ~min_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)       state_next = ST_EMPTY;
    else if (accept) state_next = ST_TRACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      out_valid  <= 1'b0;
      cur_gt     <= 1'b0;
      cur_ls     <= 1'b0;
      cur_eq     <= 1'b0;
      max_val    <= '0;
      min_val    <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      eq_cnt     <= '0;
      sample_cnt <= '0;
    end else if (clear) begin
      prev       <= '0;
      out_valid  <= 1'b0;
      cur_gt     <= 1'b0;
      cur_ls     <= 1'b0;
      cur_eq     <= 1'b0;
      max_val    <= '0;
      min_val    <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      eq_cnt     <= '0;
      sample_cnt <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        prev       <= in_data;
        sample_cnt <= sat_inc(sample_cnt);
        if (state == ST_EMPTY) begin
          // First sample after reset/clear seeds both bounds and has no reference.
          max_val <= in_data;
          min_val <= in_data;
          cur_gt  <= 1'b0;
          cur_ls  <= 1'b0;
          cur_eq  <= 1'b0;
        end else begin
          cur_gt <= prev_gt;
          cur_ls <= prev_ls;
          cur_eq <= prev_eq;
          if (prev_gt) rise_cnt <= sat_inc(rise_cnt);
          if (prev_ls) fall_cnt <= sat_inc(fall_cnt);
          if (prev_eq) eq_cnt   <= sat_inc(eq_cnt);
          if (max_upd) max_val  <= in_data;
          if (min_upd) min_val  <= in_data;
        end
      end
    end
  end

endmodule
